// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the registered ALU (alu_unit) and its barrel
// shifter (alu_shifter):
//   - opcode_e : operation select encodings (opcodes 12..15 are all NOP)
//   - cond_e   : ARM-style condition codes evaluated on the incoming flags
//   - shift_e  : shift/rotate control encodings for operand B
//   - FLAG_*   : bit positions of N, Z, C, V inside a 4-bit flag vector
//   - cond_pass: condition-code evaluation helper
// -----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_ORR  = 4'd3,
        OP_EOR  = 4'd4,
        OP_MVN  = 4'd5,
        OP_MOV  = 4'd6,
        OP_MOVI = 4'd7,
        OP_ADC  = 4'd8,
        OP_SBC  = 4'd9,
        OP_CMP  = 4'd10,
        OP_TST  = 4'd11,
        OP_NOP  = 4'd12
    } opcode_e;

    typedef enum logic [3:0] {
        CC_AL = 4'd0,
        CC_EQ = 4'd1,
        CC_NE = 4'd2,
        CC_CS = 4'd3,
        CC_CC = 4'd4,
        CC_MI = 4'd5,
        CC_PL = 4'd6,
        CC_VS = 4'd7,
        CC_VC = 4'd8,
        CC_HI = 4'd9,
        CC_LS = 4'd10,
        CC_GE = 4'd11,
        CC_LT = 4'd12,
        CC_GT = 4'd13,
        CC_LE = 4'd14,
        CC_NV = 4'd15
    } cond_e;

    typedef enum logic [2:0] {
        SH_NONE = 3'd0,
        SH_LSL  = 3'd1,
        SH_LSR  = 3'd2,
        SH_ASR  = 3'd3,
        SH_ROR  = 3'd4
    } shift_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Returns 1 when condition code cc is satisfied by flag vector f {N,Z,C,V}.
    function automatic logic cond_pass(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v, p;
        n = f[FLAG_N];
        z = f[FLAG_Z];
        c = f[FLAG_C];
        v = f[FLAG_V];
        case (cc)
            CC_AL:   p = 1'b1;
            CC_EQ:   p = z;
            CC_NE:   p = !z;
            CC_CS:   p = c;
            CC_CC:   p = !c;
            CC_MI:   p = n;
            CC_PL:   p = !n;
            CC_VS:   p = v;
            CC_VC:   p = !v;
            CC_HI:   p = c && !z;
            CC_LS:   p = !c || z;
            CC_GE:   p = (n == v);
            CC_LT:   p = (n != v);
            CC_GT:   p = !z && (n == v);
            CC_LE:   p = z || (n != v);
            default: p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// -----------------------------------------------------------------------------
// alu_shifter
// Combinational barrel shifter producing the ALU's second operand.
// Ports:
//   in2    [WIDTH-1:0] in   operand before shifting
//   srctrl [2:0]       in   shift_e selection (5..7 behave as no shift)
//   sh     [4:0]       in   shift/rotate amount; 0 leaves the value unchanged
//   op2    [WIDTH-1:0] out  shifted operand
// -----------------------------------------------------------------------------
module alu_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in2,
    input  logic [2:0]       srctrl,
    input  logic [4:0]       sh,
    output logic [WIDTH-1:0] op2
);

    logic signed [WIDTH-1:0] in2_s;
    logic signed [WIDTH-1:0] asr_s;
    logic        [WIDTH-1:0] ror_v;

    always_comb begin
        in2_s = $signed(in2);
        asr_s = in2_s >>> sh;
        // For sh=0 the left part shifts by WIDTH and vanishes, giving in2 back.
        ror_v = (in2 >> sh) | (in2 << (6'(WIDTH) - {1'b0, sh}));
        case (srctrl)
            SH_LSL:  op2 = in2 << sh;
            SH_LSR:  op2 = in2 >> sh;
            SH_ASR:  op2 = $unsigned(asr_s);
            SH_ROR:  op2 = ror_v;
            default: op2 = in2;
        endcase
    end

endmodule

// File: rtl/alu_unit.sv
// -----------------------------------------------------------------------------
// alu_unit
// 32-bit registered ALU with barrel-shifted second operand and ARM-style
// conditional execution. Result and flags appear one cycle after sampling.
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset (clears result and flags)
//   in1      in   operand A
//   in2      in   operand B before the shifter
//   s        in   1 = update flags from this operation
//   cond     in   condition code evaluated on inflags
//   opcode   in   operation select (opcode_e)
//   srctrl   in   shift control for in2 (shift_e)
//   imvalue  in   16-bit immediate; [4:0] is the shift amount
//   inflags  in   current flags {N,Z,C,V}
//   outflags out  registered flags {N,Z,C,V}
//   result   out  registered result
// Build option: define ALU_MUL_EN to replace TST (opcode 11) with MUL
// (low WIDTH bits of in1*op2, N/Z from the product, C/V passed through).
// -----------------------------------------------------------------------------
module alu_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             s,
    input  logic [3:0]       cond,
    input  logic [3:0]       opcode,
    input  logic [2:0]       srctrl,
    input  logic [15:0]      imvalue,
    input  logic [3:0]       inflags,
    output logic [3:0]       outflags,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] op2;
    logic [WIDTH-1:0] b_eff;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic             sum_v;
    logic [WIDTH-1:0] op_res;
    logic             wr_res;
    logic             upd_flags;
    logic             is_arith;
    logic             pass;
    logic [WIDTH-1:0] result_d, result_q;
    logic [3:0]       flags_d, flags_q;
`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] mul_res;
`endif

    alu_shifter #(.WIDTH(WIDTH)) u_shifter (
        .in2    (in2),
        .srctrl (srctrl),
        .sh     (imvalue[4:0]),
        .op2    (op2)
    );

`ifdef ALU_MUL_EN
    assign mul_res = in1 * op2;
`endif

    // One shared adder: subtraction is in1 + ~op2 + 1, so carry-out = !borrow.
    always_comb begin
        b_eff = op2;
        cin   = 1'b0;
        case (opcode)
            OP_SUB, OP_CMP: begin
                b_eff = ~op2;
                cin   = 1'b1;
            end
            OP_ADC: cin = inflags[FLAG_C];
            OP_SBC: begin
                b_eff = ~op2;
                cin   = inflags[FLAG_C];
            end
            default: ;
        endcase
        sum   = {1'b0, in1} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
        // Overflow: operands share a sign that the sum does not.
        sum_v = (in1[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
    end

    always_comb begin
        op_res    = '0;
        wr_res    = 1'b0;
        upd_flags = 1'b0;
        is_arith  = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
                op_res    = sum[WIDTH-1:0];
                wr_res    = 1'b1;
                upd_flags = 1'b1;
                is_arith  = 1'b1;
            end
            OP_CMP: begin
                op_res    = sum[WIDTH-1:0];
                upd_flags = 1'b1;
                is_arith  = 1'b1;
            end
            OP_AND: begin
                op_res    = in1 & op2;
                wr_res    = 1'b1;
                upd_flags = 1'b1;
            end
            OP_ORR: begin
                op_res    = in1 | op2;
                wr_res    = 1'b1;
                upd_flags = 1'b1;
            end
            OP_EOR: begin
                op_res    = in1 ^ op2;
                wr_res    = 1'b1;
                upd_flags = 1'b1;
            end
            OP_MVN: begin
                op_res    = ~op2;
                wr_res    = 1'b1;
                upd_flags = 1'b1;
            end
            OP_MOV: begin
                op_res    = op2;
                wr_res    = 1'b1;
                upd_flags = 1'b1;
            end
            OP_MOVI: begin
                op_res    = {{(WIDTH-16){1'b0}}, imvalue};
                wr_res    = 1'b1;
                upd_flags = 1'b1;
            end
            OP_TST: begin
`ifdef ALU_MUL_EN
                op_res    = mul_res;
                wr_res    = 1'b1;
`else
                op_res    = in1 & op2;
`endif
                upd_flags = 1'b1;
            end
            default: ;
        endcase
    end

    // Failed condition, NOPs and s=0 all leave the flags as they came in.
    always_comb begin
        pass     = cond_pass(cond, inflags);
        result_d = result_q;
        flags_d  = inflags;
        if (pass) begin
            if (wr_res) begin
                result_d = op_res;
            end
            if (s && upd_flags) begin
                flags_d[FLAG_N] = op_res[WIDTH-1];
                flags_d[FLAG_Z] = (op_res == '0);
                flags_d[FLAG_C] = is_arith ? sum[WIDTH] : inflags[FLAG_C];
                flags_d[FLAG_V] = is_arith ? sum_v      : inflags[FLAG_V];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign result   = result_q;
    assign outflags = flags_q;

endmodule

// File: tb/tb_alu_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_unit
// Scoreboard bench for alu_unit: the stimulus process drives one operation per
// cycle and queues its hand-computed result/flags; the monitor process pops
// and compares one cycle later, and checks zeros whenever reset is active.
// Build option ALU_MUL_EN selects the expected behaviour of opcode 11.
// -----------------------------------------------------------------------------
module tb_alu_unit;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic [3:0]  fl;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] in1 = '0;
    logic [31:0] in2 = '0;
    logic        s = 1'b0;
    logic [3:0]  cond = '0;
    logic [3:0]  opcode = 4'd12;
    logic [2:0]  srctrl = '0;
    logic [15:0] imvalue = '0;
    logic [3:0]  inflags = '0;
    logic [3:0]  outflags;
    logic [31:0] result;

    exp_t exp_q[$];
    logic issued = 1'b0;
    logic done = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    alu_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in1      (in1),
        .in2      (in2),
        .s        (s),
        .cond     (cond),
        .opcode   (opcode),
        .srctrl   (srctrl),
        .imvalue  (imvalue),
        .inflags  (inflags),
        .outflags (outflags),
        .result   (result)
    );

    always #5 clk = ~clk;

    task automatic issue(input string nm, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] sc, input logic [15:0] im,
                         input logic [3:0] cc, input logic ss,
                         input logic [3:0] fin,
                         input logic [31:0] er, input logic [3:0] ef);
        exp_t e;
        @(negedge clk);
        opcode  = op;
        in1     = a;
        in2     = b;
        srctrl  = sc;
        imvalue = im;
        cond    = cc;
        s       = ss;
        inflags = fin;
        e.name  = nm;
        e.res   = er;
        e.fl    = ef;
        exp_q.push_back(e);
        issued  = 1'b1;
    endtask

    // Stimulus
    initial begin : stim
        logic [31:0] op11_res;
        logic [3:0]  op11_fl;
`ifdef ALU_MUL_EN
        op11_res = 32'd6;
        op11_fl  = 4'b0000;
`else
        op11_res = 32'hFFFF_FFFF;
        op11_fl  = 4'b0100;
`endif
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        //     name        op     in1           in2           sc    imm       cc     s     fin      result        flags
        issue("add",       4'd0,  32'd5,        32'd11,       3'd0, 16'h0,    4'd0,  1'b1, 4'b0000, 32'd16,       4'b0000);
        issue("sub_neg",   4'd1,  32'd5,        32'd11,       3'd0, 16'h0,    4'd0,  1'b1, 4'b0000, 32'hFFFFFFFA, 4'b1000);
        issue("sub_zero",  4'd1,  32'd12,       32'd12,       3'd0, 16'h0,    4'd0,  1'b1, 4'b0000, 32'd0,        4'b0110);
        issue("add_wrap0", 4'd0,  32'd0,        32'hFFFFFFFF, 3'd0, 16'h0,    4'd0,  1'b1, 4'b0000, 32'hFFFFFFFF, 4'b1000);
        issue("add_wrap5", 4'd0,  32'd5,        32'hFFFFFFFF, 3'd0, 16'h0,    4'd0,  1'b1, 4'b0000, 32'd4,        4'b0010);
        issue("add_lsl",   4'd0,  32'd5,        32'd11,       3'd1, 16'd5,    4'd0,  1'b1, 4'b0000, 32'd357,      4'b0000);
        issue("mov_asr",   4'd6,  32'd0,        32'h80000000, 3'd3, 16'd4,    4'd0,  1'b1, 4'b0000, 32'hF8000000, 4'b1000);
        issue("eq_fail",   4'd0,  32'd7,        32'd6,        3'd0, 16'h0,    4'd1,  1'b1, 4'b0000, 32'hF8000000, 4'b0000);
        issue("eq_pass",   4'd0,  32'd7,        32'd6,        3'd0, 16'h0,    4'd1,  1'b1, 4'b0100, 32'd13,       4'b0000);
        issue("s0_pass",   4'd0,  32'd0,        32'd0,        3'd0, 16'h0,    4'd0,  1'b0, 4'b1010, 32'd0,        4'b1010);
        issue("mov",       4'd6,  32'd0,        32'h1234,     3'd0, 16'h0,    4'd0,  1'b0, 4'b0000, 32'h1234,     4'b0000);
        issue("cmp",       4'd10, 32'd12,       32'd12,       3'd0, 16'h0,    4'd0,  1'b1, 4'b0000, 32'h1234,     4'b0110);
        issue("nop15",     4'd15, 32'd3,        32'd4,        3'd0, 16'h0,    4'd0,  1'b1, 4'b1011, 32'h1234,     4'b1011);
        issue("mov_lsr",   4'd6,  32'd0,        32'h80000000, 3'd2, 16'd4,    4'd0,  1'b0, 4'b0000, 32'h08000000, 4'b0000);
        issue("mov_ror",   4'd6,  32'd0,        32'h0000000F, 3'd4, 16'd4,    4'd0,  1'b0, 4'b0000, 32'hF0000000, 4'b0000);
        issue("lsl_sh0",   4'd6,  32'd0,        32'h0000ABCD, 3'd1, 16'h0020, 4'd0,  1'b0, 4'b0000, 32'h0000ABCD, 4'b0000);
        issue("movi",      4'd7,  32'd0,        32'h12345678, 3'd1, 16'hBEEF, 4'd0,  1'b0, 4'b0000, 32'h0000BEEF, 4'b0000);
        issue("adc",       4'd8,  32'd1,        32'd1,        3'd0, 16'h0,    4'd0,  1'b1, 4'b0010, 32'd3,        4'b0000);
        issue("sbc",       4'd9,  32'd5,        32'd3,        3'd0, 16'h0,    4'd0,  1'b1, 4'b0000, 32'd1,        4'b0010);
        issue("add_ovf",   4'd0,  32'h7FFFFFFF, 32'd1,        3'd0, 16'h0,    4'd0,  1'b1, 4'b0000, 32'h80000000, 4'b1001);
        issue("and",       4'd2,  32'hFF00FF00, 32'h0FF00FF0, 3'd0, 16'h0,    4'd0,  1'b1, 4'b0011, 32'h0F000F00, 4'b0011);
        issue("orr",       4'd3,  32'h000000F0, 32'h0000000F, 3'd0, 16'h0,    4'd0,  1'b1, 4'b0000, 32'h000000FF, 4'b0000);
        issue("eor",       4'd4,  32'h000000FF, 32'h000000FF, 3'd0, 16'h0,    4'd0,  1'b1, 4'b0000, 32'd0,        4'b0100);
        issue("mvn",       4'd5,  32'd0,        32'd0,        3'd0, 16'h0,    4'd0,  1'b1, 4'b0000, 32'hFFFFFFFF, 4'b1000);
        issue("op11",      4'd11, 32'd6,        32'd1,        3'd0, 16'h0,    4'd0,  1'b1, 4'b0000, op11_res,     op11_fl);
        issue("nv",        4'd0,  32'd1,        32'd1,        3'd0, 16'h0,    4'd15, 1'b1, 4'b1111, op11_res,     4'b1111);
        issue("gt_pass",   4'd0,  32'd1,        32'd1,        3'd0, 16'h0,    4'd13, 1'b0, 4'b0000, 32'd2,        4'b0000);
        issue("lt_pass",   4'd6,  32'd0,        32'd9,        3'd0, 16'h0,    4'd12, 1'b0, 4'b1000, 32'd9,        4'b1000);
        issue("gt_fail",   4'd0,  32'd1,        32'd1,        3'd0, 16'h0,    4'd13, 1'b1, 4'b0100, 32'd9,        4'b0100);

        // Mid-stream reset with an operation presented: nothing may land.
        @(negedge clk);
        issued  = 1'b0;
        opcode  = 4'd0;
        in1     = 32'd1;
        in2     = 32'd1;
        cond    = 4'd0;
        s       = 1'b1;
        inflags = 4'b1111;
        rst_n   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        issue("post_rst",  4'd0,  32'd2,        32'd3,        3'd0, 16'h0,    4'd0,  1'b1, 4'b0000, 32'd5,        4'b0000);
        @(negedge clk);
        issued = 1'b0;
        @(negedge clk);
        done = 1'b1;
    end

    // Monitor / scoreboard
    initial begin : mon
        exp_t e;
        logic cap;
        while (!done) begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                #1;
                n_checks++;
                if (result !== 32'd0 || outflags !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL reset: result=%h flags=%b, required result=00000000 flags=0000",
                             result, outflags);
                end
            end else begin
                cap = issued;
                #1;
                if (cap) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL scoreboard: output with no queued expectation at %0t", $time);
                    end else begin
                        e = exp_q.pop_front();
                        if (result !== e.res || outflags !== e.fl) begin
                            n_fail++;
                            $display("FAIL %s: result=%h flags=%b, required result=%h flags=%b",
                                     e.name, result, outflags, e.res, e.fl);
                        end
                    end
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL timeout: simulation did not complete, required completion before 100000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_unit.md
Name: alu_unit

Overview:
- 32-bit registered ALU for the processor datapath.
- Takes two register operands, a 16-bit immediate, a condition code and the incoming NZCV flags.
- Second operand passes through a barrel shifter before the operation executes.
- Result and flags are registered with one-cycle latency; execution is predicated on the condition code, ARM style.

Parameters:
- WIDTH, 32, datapath width (only 32 is required to be supported).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in1  input  32  operand A
- in2  input  32  operand B, pre-shift
- s  input  1  1 = update flags from this operation
- cond  input  4  condition code
- opcode  input  4  operation select
- srctrl  input  3  shift/rotate control applied to in2
- imvalue  input  16  immediate; [4:0] is also the shift amount
- inflags  input  4  current flags {N,Z,C,V}
- outflags  output  4  registered flags {N,Z,C,V}
- result  output  32  registered result

Behaviour:
- Reset (async, rst_n=0): result=0, outflags=0. Reset mid-operation discards any pending update.
- Latency: inputs sampled at a clk rising edge appear on result/outflags after that edge. No handshake; one operation is accepted per cycle.
- Shifter: op2 = in2 shifted by sh = imvalue[4:0]:
  - srctrl 0: none
  - srctrl 1: LSL
  - srctrl 2: LSR
  - srctrl 3: ASR
  - srctrl 4: ROR
  - srctrl 5-7: none
  - sh=0 leaves the value unchanged.
- Conditions, evaluated on inflags:
  - 0 AL, 1 EQ(Z), 2 NE(!Z), 3 CS(C), 4 CC(!C)
  - 5 MI(N), 6 PL(!N), 7 VS(V), 8 VC(!V)
  - 9 HI(C&!Z), 10 LS(!C|Z)
  - 11 GE(N==V), 12 LT(N!=V)
  - 13 GT(!Z&N==V), 14 LE(Z|N!=V)
  - 15 NV(never)
- Condition false: result register holds its value; outflags <= inflags.
- Opcodes:
  - 0 ADD in1+op2
  - 1 SUB in1-op2
  - 2 AND
  - 3 ORR
  - 4 EOR
  - 5 MVN ~op2
  - 6 MOV op2
  - 7 MOVI {16'b0,imvalue}, unshifted
  - 8 ADC in1+op2+C
  - 9 SBC in1-op2-!C
  - 10 CMP: SUB flags only, result held
  - 11 TST: AND flags only, result held (overridden by MUL when ALU_MUL_EN is defined; see Optional Feature)
  - 12-15 NOP: result held, outflags <= inflags
- Flags, applied when s=1 and the condition passes:
  - N = res[31]; Z = (res==0).
  - Arithmetic ops: C = carry out of bit 31; subtract uses C=1 for no borrow. V = signed overflow.
  - Logical and move ops: C and V copied from inflags.
- s=0: outflags <= inflags (flags pass through unchanged).
- All arithmetic is modulo 2^32; wrap-around sets C and clears Z only per the rules above.

Optional Feature:
- Macro ALU_MUL_EN.
- Defined: opcode 11 = MUL, result = low 32 bits of in1*op2. N and Z from the result; C and V from inflags.
- Undefined: opcode 11 = TST as listed under Behaviour.

Decomposition:
- Package alu_pkg holds:
  - opcode enum (OP_ADD..OP_NOP)
  - condition enum (CC_AL..CC_NV)
  - shift enum (SH_NONE, SH_LSL, SH_LSR, SH_ASR, SH_ROR)
  - flag bit index constants (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0)
- One sub-module, alu_shifter: combinational barrel shifter producing op2 from in2, srctrl and sh.

Test Plan:
- Reset: assert rst_n=0 mid-stream -> result=0, outflags=0000 immediately.
- Arithmetic, cond=0, s=1, srctrl=0:
  - ADD 5+11 -> 16, flags 0000.
  - SUB 5-11 -> 0xFFFFFFFA, flags 1000.
  - SUB 12-12 -> 0, flags 0110.
- Wrap: ADD 0+0xFFFFFFFF -> 0xFFFFFFFF, flags 1000; ADD 5+0xFFFFFFFF -> 4, flags 0010.
- Shifter: ADD in1=5, in2=11, srctrl=1, imvalue=5 -> 357.
  - srctrl=3 with in2=0x80000000, imvalue=4 -> op2 0xF8000000 (check via MOV).
- Predication: cond=1 (EQ) with inflags=0000, ADD 7+6 -> result holds previous value, outflags=0000.
  - Same with inflags=0100 -> 13.
- Flag control:
  - s=0, ADD 0+0 with inflags=1010 -> result 0, outflags 1010.
  - CMP 12,12 -> result held, flags 0110.
  - opcode 15 -> result held, outflags=inflags.
